// File: rtl/game_pkg.sv
// Shared types and encodings for the quiz-game controller.
// Holds the FSM state enum, checker verdict codes and lamp display codes.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_JUDGE,
        S_SHOW,
        S_OVER
    } state_t;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_CORRECT = 2'b01;
    localparam logic [1:0] RES_WRONG   = 2'b10;

    localparam logic [1:0] LAMP_OFF     = 2'b00;
    localparam logic [1:0] LAMP_CORRECT = 2'b01;
    localparam logic [1:0] LAMP_WRONG   = 2'b10;
    localparam logic [1:0] LAMP_TIMEOUT = 2'b11;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/game_timer.sv
// Loadable down-counter for the per-problem time budget.
// Holds at zero rather than wrapping; load has priority over the tick.
module game_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick_en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick_en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/game_ctrl.sv
// Quiz-game sequencer: problem index, per-problem timer, checker handshake,
// verdict lamp with hold time, and score keeping. All outputs are registered.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned NUM_PROB    = 10,
    parameter int unsigned TIME_LIMIT  = 30,
    parameter int unsigned RESULT_HOLD = 3,
    parameter int unsigned JUDGE_WAIT  = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       SUBMIT,
    input  logic       TICK,
    input  logic [1:0] RESULT,
    output logic [3:0] PROB_IDX,
    output logic       INPUT_EN,
    output logic       CHECK_REQ,
    output logic [3:0] SCORE,
    output logic [5:0] TIME_LEFT,
    output logic [1:0] LAMP,
    output logic       DONE
);

    localparam int unsigned WAIT_W = (JUDGE_WAIT > 1) ? $clog2(JUDGE_WAIT) : 1;

    state_t            state, state_nxt;
    logic [3:0]        prob_nxt, score_nxt, hold_cnt, hold_nxt;
    logic [1:0]        lamp_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              check_nxt, tmr_load, tmr_tick, tmr_zero, expire;

    game_timer #(.W(6)) u_timer (
        .clk      (CLK),
        .rst      (RST),
        .load     (tmr_load),
        .load_val (6'(TIME_LIMIT)),
        .tick_en  (tmr_tick),
        .count    (TIME_LEFT),
        .zero     (tmr_zero)
    );

    // SUBMIT outranks the expiring tick, so expiry is only acted on when SUBMIT is low.
    assign expire = TICK && ((TIME_LEFT == 6'd1) || tmr_zero);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_IDLE;
            PROB_IDX  <= '0;
            SCORE     <= '0;
            LAMP      <= '0;
            DONE      <= 1'b0;
            CHECK_REQ <= 1'b0;
            INPUT_EN  <= 1'b0;
            hold_cnt  <= '0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            PROB_IDX  <= prob_nxt;
            SCORE     <= score_nxt;
            LAMP      <= lamp_nxt;
            DONE      <= (state_nxt == S_OVER);
            CHECK_REQ <= check_nxt;
            INPUT_EN  <= (state_nxt == S_PLAY);
            hold_cnt  <= hold_nxt;
            wait_cnt  <= wait_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prob_nxt  = PROB_IDX;
        score_nxt = SCORE;
        lamp_nxt  = LAMP;
        hold_nxt  = hold_cnt;
        wait_nxt  = wait_cnt;
        check_nxt = 1'b0;
        tmr_load  = 1'b0;
        tmr_tick  = 1'b0;

        case (state)
            S_IDLE, S_OVER: begin
                if (START) begin
                    state_nxt = S_PLAY;
                    prob_nxt  = '0;
                    score_nxt = '0;
                    lamp_nxt  = LAMP_OFF;
                    tmr_load  = 1'b1;
                end
            end
            S_PLAY: begin
                if (SUBMIT) begin
                    state_nxt = S_JUDGE;
                    check_nxt = 1'b1;
                    wait_nxt  = '0;
                end else if (TICK) begin
                    tmr_tick = 1'b1;
                    if (expire) begin
                        state_nxt = S_SHOW;
                        lamp_nxt  = LAMP_TIMEOUT;
                        hold_nxt  = '0;
                    end
                end
            end
            S_JUDGE: begin
                if (RESULT != RES_NONE) begin
                    state_nxt = S_SHOW;
                    hold_nxt  = '0;
                    if (RESULT == RES_CORRECT) begin
                        lamp_nxt  = LAMP_CORRECT;
                        score_nxt = sat_inc(SCORE);
                    end else begin
                        lamp_nxt = LAMP_WRONG;
                    end
                end else if (wait_cnt == WAIT_W'(JUDGE_WAIT - 1)) begin
                    state_nxt = S_SHOW;
                    hold_nxt  = '0;
                    lamp_nxt  = LAMP_WRONG;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            S_SHOW: begin
                if (TICK) begin
                    if (hold_cnt == 4'(RESULT_HOLD - 1)) begin
                        if (PROB_IDX == 4'(NUM_PROB - 1)) begin
                            state_nxt = S_OVER;
                        end else begin
                            state_nxt = S_PLAY;
                            prob_nxt  = PROB_IDX + 4'd1;
                            lamp_nxt  = LAMP_OFF;
                            tmr_load  = 1'b1;
                        end
                    end else begin
                        hold_nxt = hold_cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench: two controllers (2 and 4 problems) share stimulus and are
// compared every cycle against a phase-level model, plus directed scenario checks.
module tb_game_ctrl;

    localparam int TIME_LIMIT  = 30;
    localparam int RESULT_HOLD = 3;
    localparam int JUDGE_WAIT  = 16;

    logic       clk = 1'b0;
    logic       rst, start, submit, tick;
    logic [1:0] result;
    logic [3:0] prob_idx  [2];
    logic [3:0] score     [2];
    logic [5:0] time_left [2];
    logic [1:0] lamp      [2];
    logic       input_en  [2];
    logic       check_req [2];
    logic       done      [2];

    game_ctrl #(.NUM_PROB(2), .TIME_LIMIT(TIME_LIMIT), .RESULT_HOLD(RESULT_HOLD),
                .JUDGE_WAIT(JUDGE_WAIT)) dut2 (
        .CLK(clk), .RST(rst), .START(start), .SUBMIT(submit), .TICK(tick),
        .RESULT(result), .PROB_IDX(prob_idx[0]), .INPUT_EN(input_en[0]),
        .CHECK_REQ(check_req[0]), .SCORE(score[0]), .TIME_LEFT(time_left[0]),
        .LAMP(lamp[0]), .DONE(done[0]));

    game_ctrl #(.NUM_PROB(4), .TIME_LIMIT(TIME_LIMIT), .RESULT_HOLD(RESULT_HOLD),
                .JUDGE_WAIT(JUDGE_WAIT)) dut4 (
        .CLK(clk), .RST(rst), .START(start), .SUBMIT(submit), .TICK(tick),
        .RESULT(result), .PROB_IDX(prob_idx[1]), .INPUT_EN(input_en[1]),
        .CHECK_REQ(check_req[1]), .SCORE(score[1]), .TIME_LEFT(time_left[1]),
        .LAMP(lamp[1]), .DONE(done[1]));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference model: game phase as text, counters as elapsed cycles/ticks.
    string ph      [2];
    int    m_prob  [2];
    int    m_score [2];
    int    m_time  [2];
    int    m_lamp  [2];
    int    m_chk   [2];
    int    m_wait  [2];
    int    m_hold  [2];

    function automatic int nprob(input int i);
        return (i == 0) ? 2 : 4;
    endfunction

    task automatic model_step(input int i);
        m_chk[i] = 0;
        if (!rst) begin
            ph[i] = "IDLE";
            m_prob[i] = 0; m_score[i] = 0; m_time[i] = 0; m_lamp[i] = 0;
            m_wait[i] = 0; m_hold[i] = 0;
        end else if (ph[i] == "IDLE" || ph[i] == "OVER") begin
            if (start) begin
                ph[i] = "PLAY";
                m_prob[i] = 0; m_score[i] = 0; m_time[i] = TIME_LIMIT; m_lamp[i] = 0;
            end
        end else if (ph[i] == "PLAY") begin
            if (submit) begin
                ph[i] = "JUDGE"; m_chk[i] = 1; m_wait[i] = 0;
            end else if (tick) begin
                m_time[i] = m_time[i] - 1;
                if (m_time[i] == 0) begin
                    ph[i] = "SHOW"; m_lamp[i] = 3; m_hold[i] = 0;
                end
            end
        end else if (ph[i] == "JUDGE") begin
            m_wait[i] = m_wait[i] + 1;
            if (result != 2'b00) begin
                ph[i] = "SHOW"; m_hold[i] = 0;
                if (result == 2'b01) begin
                    m_lamp[i]  = 1;
                    m_score[i] = (m_score[i] < 15) ? m_score[i] + 1 : 15;
                end else begin
                    m_lamp[i] = 2;
                end
            end else if (m_wait[i] == JUDGE_WAIT) begin
                ph[i] = "SHOW"; m_hold[i] = 0; m_lamp[i] = 2;
            end
        end else if (ph[i] == "SHOW") begin
            if (tick) begin
                m_hold[i] = m_hold[i] + 1;
                if (m_hold[i] == RESULT_HOLD) begin
                    if (m_prob[i] == nprob(i) - 1) begin
                        ph[i] = "OVER";
                    end else begin
                        ph[i] = "PLAY"; m_prob[i]++; m_time[i] = TIME_LIMIT; m_lamp[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("prob%0d", i),   int'(prob_idx[i]),  m_prob[i]);
            check($sformatf("score%0d", i),  int'(score[i]),     m_score[i]);
            check($sformatf("time%0d", i),   int'(time_left[i]), m_time[i]);
            check($sformatf("lamp%0d", i),   int'(lamp[i]),      m_lamp[i]);
            check($sformatf("chkreq%0d", i), int'(check_req[i]), m_chk[i]);
            check($sformatf("inen%0d", i),   int'(input_en[i]),  (ph[i] == "PLAY") ? 1 : 0);
            check($sformatf("done%0d", i),   int'(done[i]),      (ph[i] == "OVER") ? 1 : 0);
        end
    endtask

    task automatic cyc(input bit st, input bit sb, input bit tk, input logic [1:0] rs);
        start = st; submit = sb; tick = tk; result = rs;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; submit = 1'b0; tick = 1'b0; result = 2'b00;
        for (int i = 0; i < 2; i++) ph[i] = "IDLE";
        cyc(0, 0, 0, 2'b00);
        cyc(0, 0, 0, 2'b00);
        check("rst_prob", int'(prob_idx[0]), 0);
        check("rst_time", int'(time_left[0]), 0);
        check("rst_done", int'(done[0]), 0);
        rst = 1'b1;

        // Normal game: two correct answers on the 2-problem instance.
        cyc(1, 0, 0, 2'b00);
        check("start_time", int'(time_left[0]), 30);
        check("start_inen", int'(input_en[0]), 1);
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 5; t++) cyc(0, 0, 1, 2'b00);
            cyc(0, 1, 0, 2'b00);
            check("sub_time", int'(time_left[0]), 25);
            check("sub_chkreq", int'(check_req[0]), 1);
            cyc(0, 0, 0, 2'b00);
            check("chkreq_once", int'(check_req[0]), 0);
            cyc(0, 0, 0, 2'b01);
            check("ok_lamp", int'(lamp[0]), 1);
            check("ok_score", int'(score[0]), p + 1);
            for (int t = 0; t < 3; t++) begin
                cyc(0, 0, 1, 2'b00);
                cyc(0, 0, 0, 2'b00);
            end
            if (p == 0) check("adv_prob", int'(prob_idx[0]), 1);
        end
        check("over_done", int'(done[0]), 1);
        check("over_score", int'(score[0]), 2);

        // 4-problem instance: result in PLAY ignored, START in JUDGE ignored.
        cyc(0, 0, 0, 2'b01);
        check("play_res_ign", int'(score[1]), 2);
        cyc(0, 1, 0, 2'b00);
        cyc(1, 0, 0, 2'b00);
        check("judge_start_prob", int'(prob_idx[1]), 2);
        check("judge_start_inen", int'(input_en[1]), 0);
        cyc(0, 0, 0, 2'b01);
        check("show_score3", int'(score[1]), 3);
        rst = 1'b0;
        cyc(0, 0, 0, 2'b00);
        check("mid_rst_score", int'(score[1]), 0);
        check("mid_rst_lamp", int'(lamp[1]), 0);
        check("mid_rst_chk", int'(check_req[1]), 0);
        rst = 1'b1;

        // Timeout, then SUBMIT right after expiry is ignored.
        cyc(1, 0, 0, 2'b00);
        for (int t = 0; t < 29; t++) cyc(0, 0, 1, 2'b00);
        check("pre_to_time", int'(time_left[0]), 1);
        cyc(0, 0, 1, 2'b00);
        check("to_time", int'(time_left[0]), 0);
        check("to_lamp", int'(lamp[0]), 3);
        check("to_score", int'(score[0]), 0);
        cyc(0, 1, 0, 2'b00);
        check("to_sub_ign", int'(check_req[0]), 0);
        for (int t = 0; t < 3; t++) cyc(0, 0, 1, 2'b00);
        check("to_adv_prob", int'(prob_idx[0]), 1);

        // Collision with the expiring tick, then checker silence.
        for (int t = 0; t < 29; t++) cyc(0, 0, 1, 2'b00);
        cyc(0, 1, 1, 2'b00);
        check("col_time", int'(time_left[0]), 1);
        check("col_chkreq", int'(check_req[0]), 1);
        for (int c = 0; c < 15; c++) cyc(0, 0, 1, 2'b00);
        check("silent_pre", int'(lamp[0]), 0);
        check("silent_time", int'(time_left[0]), 1);
        cyc(0, 0, 0, 2'b00);
        check("silent_lamp", int'(lamp[0]), 2);
        check("silent_score", int'(score[0]), 0);

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter NUM_PROB, default 10: problems per game, range 1..15.
REQ-002 SHALL have parameter TIME_LIMIT, default 30: TICKs allowed per problem, range 1..63.
REQ-003 SHALL have parameter RESULT_HOLD, default 3: TICKs the verdict is displayed, range 1..15.
REQ-004 SHALL have parameter JUDGE_WAIT, default 16: CLK cycles to wait for a checker verdict.
REQ-005 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port RST, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port START, input, 1 bit: one-cycle pulse from the debounced button.
REQ-008 SHALL have port SUBMIT, input, 1 bit: one-cycle pulse that submits the player's answer.
REQ-009 SHALL have port TICK, input, 1 bit: one-cycle 1 Hz strobe.
REQ-010 SHALL have port RESULT, input, 2 bits: checker verdict; 00 none, 01 correct, 10 wrong, 11 treated as wrong.
REQ-011 SHALL have port PROB_IDX, output, 4 bits: current problem number.
REQ-012 SHALL have port INPUT_EN, output, 1 bit: enables digit edits in the input block.
REQ-013 SHALL have port CHECK_REQ, output, 1 bit: one-cycle request to the checker.
REQ-014 SHALL have port SCORE, output, 4 bits: count of correct answers.
REQ-015 SHALL have port TIME_LEFT, output, 6 bits: remaining TICKs for the current problem.
REQ-016 SHALL have port LAMP, output, 2 bits: verdict display; 00 off, 01 correct, 10 wrong, 11 timeout.
REQ-017 SHALL have port DONE, output, 1 bit: game over.

Function
REQ-018 SHALL implement the states IDLE, PLAY, JUDGE, SHOW and OVER; all outputs SHALL be registered.
REQ-019 In IDLE, a START pulse SHALL, on the next edge, enter PLAY with PROB_IDX=0, SCORE=0, TIME_LEFT=TIME_LIMIT and LAMP=00.
REQ-020 INPUT_EN SHALL be 1 only in PLAY.
REQ-021 In PLAY, each TICK SHALL decrement TIME_LEFT by 1.
REQ-022 In PLAY, a TICK while TIME_LEFT=1 SHALL set TIME_LEFT=0 and LAMP=11 and enter SHOW; SCORE SHALL be unchanged.
REQ-023 In PLAY, SUBMIT SHALL enter JUDGE, and CHECK_REQ SHALL be high for exactly the first JUDGE cycle.
REQ-024 When SUBMIT and the expiring TICK arrive in the same cycle, SUBMIT SHALL win and TIME_LEFT SHALL be frozen at 1.
REQ-025 In JUDGE, TIME_LEFT SHALL be frozen and TICKs SHALL be ignored.
REQ-026 In JUDGE, the first RESULT other than 00 SHALL decide the verdict: 01 gives LAMP=01 and SCORE+1 (saturating at 15); 10 or 11 gives LAMP=10.
REQ-027 In JUDGE, JUDGE_WAIT cycles with RESULT=00 SHALL be treated as wrong (LAMP=10).
REQ-028 A RESULT value other than 00 in any state other than JUDGE SHALL be ignored.
REQ-029 In SHOW, the FSM SHALL count TICKs; after RESULT_HOLD TICKs it SHALL advance.
REQ-030 On advance, if PROB_IDX=NUM_PROB-1 the FSM SHALL enter OVER.
REQ-031 On advance otherwise, it SHALL increment PROB_IDX, reload TIME_LEFT=TIME_LIMIT, set LAMP=00 and enter PLAY.
REQ-032 In OVER, DONE SHALL be 1, and SCORE and LAMP SHALL be held.
REQ-033 In OVER, START SHALL reinitialise exactly as in REQ-019 and clear DONE.
REQ-034 START SHALL be ignored in PLAY, JUDGE and SHOW.
REQ-035 SUBMIT SHALL be ignored outside PLAY, including a SUBMIT that coincides with the PLAY-to-SHOW timeout transition.

Reset
REQ-036 While RST=0 at a CLK edge, the FSM SHALL go to IDLE, and PROB_IDX, SCORE, TIME_LEFT, LAMP, DONE, CHECK_REQ, INPUT_EN and all internal counters SHALL be cleared to 0.
REQ-037 Reset SHALL take effect from any state mid-game with no residual CHECK_REQ pulse.
REQ-038 The first START accepted after RST returns high SHALL behave as in REQ-019.

Structure
REQ-039 The shared package game_pkg SHALL hold the state enum, the RESULT encodings and the LAMP encodings.
REQ-040 The TIME_LEFT down-counter SHALL be a sub-module game_timer, with ports load, load value, tick enable, count output and a zero flag.
REQ-041 The FSM, the SCORE register, the hold counter and the judge-wait counter SHALL live in game_ctrl.

Verification
REQ-042 Scenario (normal game, NUM_PROB=2): START; for each problem, 5 TICKs then SUBMIT with RESULT=01 two cycles later -> CHECK_REQ one cycle each time, TIME_LEFT=25 at each SUBMIT, LAMP=01, and after 3 TICKs PROB_IDX=1 then DONE=1 with SCORE=2.
REQ-043 Scenario (timeout): START, then 30 TICKs with no SUBMIT -> TIME_LEFT=0, LAMP=11, SCORE=0, then PROB_IDX=1 after 3 TICKs.
REQ-044 Scenario (collision): SUBMIT coincident with the TICK at TIME_LEFT=1 -> JUDGE entered, TIME_LEFT stays 1, CHECK_REQ=1.
REQ-045 Scenario (checker silence): SUBMIT with RESULT held at 00 -> LAMP=10 exactly 16 cycles after entering JUDGE, SCORE unchanged.
REQ-046 Scenario (reset and ignored inputs): RST=0 during SHOW with SCORE=3 -> next cycle IDLE with all outputs 0; START during JUDGE has no effect; RESULT=01 during PLAY does not change SCORE.
